// File: rtl/mips_mem_arbiter_pkg.sv
// mips_mem_arb_pkg: shared states, grant encoding and bus widths for the instruction/data memory arbiter.
package mips_mem_arb_pkg;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arbState;
  typedef enum logic {GNT_INST, GNT_DATA} grantPort;
endpackage

// File: rtl/mips_mem_arbiter_timeout.sv
// mips_mem_timeout: watchdog counting busy cycles; expired flags the LIMIT-th consecutive enabled cycle.
module mips_mem_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] count;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  end
  assign expired = enable && count == W'(LIMIT - 1);
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: serialises instruction and data memory ports onto one req/ack memory bus.
// Define MIPS_MEM_ARB_TIMEOUT_EN to force-complete transactions whose Mem_Ack never arrives.
module mips_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              DataMem_Read,
  input  logic [3:0]        DataMem_Write,
  input  logic [ADDR_W-1:0] DataMem_Address,
  input  logic [DATA_W-1:0] DataMem_Out,
  output logic [DATA_W-1:0] DataMem_In,
  output logic              DataMem_Ready,
  input  logic              InstMem_Read,
  input  logic [ADDR_W-1:0] InstMem_Address,
  output logic [DATA_W-1:0] InstMem_In,
  output logic              InstMem_Ready,
  output logic              Mem_Req,
  output logic [3:0]        Mem_We,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  input  logic              Mem_Ack,
  output logic              Arb_Timeout
);
  arbState state, nextState;
  grantPort lastGrant;
  logic dataPend, instPend, pickData, timedOut, done;
  logic [DATA_W-1:0] rData;

  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MIPS_MEM_ARB_TIMEOUT_EN
  mips_mem_timeout #(.LIMIT(TIMEOUT_CYCLES)) watchdog (
    .clock,
    .reset,
    .clear(state != BUSY),
    .enable(state == BUSY),
    .expired(timedOut)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) Arb_Timeout <= 1'b0;
    else if (state == BUSY && timedOut && !Mem_Ack) Arb_Timeout <= 1'b1;
  end
`else
  assign timedOut = 1'b0;
  assign Arb_Timeout = 1'b0;
`endif

  // Contention goes to the port opposite the previous grant; a lone requester always wins.
  always_comb begin
    dataPend = DataMem_Read | (|DataMem_Write);
    instPend = InstMem_Read;
    pickData = dataPend && (!instPend || lastGrant == GNT_INST);
    done = Mem_Ack | timedOut;
    rData = Mem_Ack ? Mem_RData : ERR_DATA;
    nextState = state == IDLE ? ((dataPend || instPend) ? BUSY : IDLE)
              : state == BUSY ? (done ? RESP : BUSY) : IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lastGrant <= GNT_INST;
      Mem_Req <= 1'b0;
      Mem_We <= '0;
      Mem_Address <= '0;
      Mem_WData <= '0;
      DataMem_In <= '0;
      InstMem_In <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && (dataPend || instPend)) begin
        lastGrant <= pickData ? GNT_DATA : GNT_INST;
        Mem_Req <= 1'b1;
        Mem_Address <= pickData ? DataMem_Address : InstMem_Address;
        Mem_We <= pickData ? DataMem_Write : '0;
        Mem_WData <= pickData ? DataMem_Out : '0;
      end
      if (state == BUSY && done) begin
        Mem_Req <= 1'b0;
        Mem_We <= '0;
        if (lastGrant == GNT_DATA) DataMem_In <= rData;
        else InstMem_In <= rData;
      end
    end
  end

  // lastGrant doubles as the owner of the transaction being answered in RESP.
  assign DataMem_Ready = state == RESP && lastGrant == GNT_DATA;
  assign InstMem_Ready = state == RESP && lastGrant == GNT_INST;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: randomized processor/memory traffic checked against a transaction-level model,
// followed by directed latency, wait-state, reset and (with MIPS_MEM_ARB_TIMEOUT_EN) watchdog cases.
module tb_mips_mem_arbiter;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  logic clock = 1'b0, reset = 1'b0;
  logic DataMem_Read, DataMem_Ready, InstMem_Read, InstMem_Ready, Mem_Req, Mem_Ack, Arb_Timeout;
  logic [3:0] DataMem_Write, Mem_We;
  logic [29:0] DataMem_Address, InstMem_Address, Mem_Address;
  logic [31:0] DataMem_Out, DataMem_In, InstMem_In, Mem_WData, Mem_RData;
  int total = 0, bad = 0;
  logic [31:0] mem [16];
  bit open, isData, lastData, expReq, expIRdy, expDRdy, dropI, dropD, ack, inResp, pendI, pendD, seen;
  logic [29:0] expAddr;
  logic [3:0] expWe;
  logic [31:0] expWData, expIIn, expDIn;
  int waitLeft, rw, n;

  always #5 clock = ~clock;

  mips_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write), .DataMem_Address(DataMem_Address),
    .DataMem_Out(DataMem_Out), .DataMem_In(DataMem_In), .DataMem_Ready(DataMem_Ready),
    .InstMem_Read(InstMem_Read), .InstMem_Address(InstMem_Address), .InstMem_In(InstMem_In),
    .InstMem_Ready(InstMem_Ready), .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Address(Mem_Address),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack), .Arb_Timeout(Arb_Timeout)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkEq({tag, "Req"}, Mem_Req, 0);
    checkEq({tag, "We"}, Mem_We, 0);
    checkEq({tag, "Addr"}, Mem_Address, 0);
    checkEq({tag, "WData"}, Mem_WData, 0);
    checkEq({tag, "DIn"}, DataMem_In, 0);
    checkEq({tag, "IIn"}, InstMem_In, 0);
    checkEq({tag, "DRdy"}, DataMem_Ready, 0);
    checkEq({tag, "IRdy"}, InstMem_Ready, 0);
    checkEq({tag, "Tmo"}, Arb_Timeout, 0);
  endtask

  task automatic checkCycle();
    checkEq("memReq", Mem_Req, expReq);
    if (expReq) begin
      checkEq("memAddr", Mem_Address, expAddr);
      checkEq("memWe", Mem_We, expWe);
      if (isData) checkEq("memWData", Mem_WData, expWData);
    end else checkEq("memWeIdle", Mem_We, 0);
    checkEq("instRdy", InstMem_Ready, expIRdy);
    checkEq("dataRdy", DataMem_Ready, expDRdy);
    checkEq("instIn", InstMem_In, expIIn);
    checkEq("dataIn", DataMem_In, expDIn);
    checkEq("arbTimeout", Arb_Timeout, 0);
  endtask

  initial begin
    DataMem_Read = 0; DataMem_Write = 0; DataMem_Address = 0; DataMem_Out = 0;
    InstMem_Read = 0; InstMem_Address = 0; Mem_RData = 0; Mem_Ack = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    @(negedge clock);
    checkZeroOutputs("rst");
    reset = 1;
    // Random traffic: processor holds requests until Ready, memory acks after 0..3 wait cycles.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      checkCycle();
      if (dropI) InstMem_Read = 0;
      if (dropD) begin DataMem_Read = 0; DataMem_Write = 0; end
      dropI = expIRdy;
      dropD = expDRdy;
      if (open && $urandom_range(0, 15) == 0) begin
        if (isData) begin DataMem_Read = 0; DataMem_Write = 0; end
        else InstMem_Read = 0;
      end
      if (!InstMem_Read && !dropI && !(open && !isData) && (cyc == 0 || $urandom_range(0, 1) == 1)) begin
        InstMem_Read = 1;
        InstMem_Address = 30'($urandom_range(0, 15));
      end
      if (!DataMem_Read && DataMem_Write == 0 && !dropD && !(open && isData) && (cyc == 0 || $urandom_range(0, 1) == 1)) begin
        rw = $urandom_range(0, 2);
        DataMem_Read = rw != 1;
        DataMem_Write = rw == 0 ? 4'b0 : 4'($urandom_range(1, 15));
        DataMem_Address = 30'($urandom_range(0, 15));
        DataMem_Out = $urandom;
      end
      ack = open && waitLeft == 0;
      Mem_RData = ack ? mem[expAddr[3:0]] : $urandom;
      Mem_Ack = ack || (!open && $urandom_range(0, 7) == 0);
      inResp = expIRdy || expDRdy;
      expIRdy = 0;
      expDRdy = 0;
      pendI = InstMem_Read;
      pendD = DataMem_Read || DataMem_Write != 0;
      if (ack) begin
        if (isData) begin
          expDIn = Mem_RData;
          for (int b = 0; b < 4; b++) if (expWe[b]) mem[expAddr[3:0]][8*b +: 8] = expWData[8*b +: 8];
        end else expIIn = Mem_RData;
        expDRdy = isData;
        expIRdy = !isData;
        open = 0;
        expReq = 0;
      end else if (open) waitLeft--;
      else if (!inResp && (pendI || pendD)) begin
        isData = (pendI && pendD) ? !lastData : pendD;
        lastData = isData;
        expAddr = isData ? DataMem_Address : InstMem_Address;
        expWe = isData ? DataMem_Write : 4'b0;
        expWData = isData ? DataMem_Out : 32'b0;
        open = 1;
        expReq = 1;
        waitLeft = $urandom_range(0, 3);
      end
    end
    @(negedge clock);
    InstMem_Read = 0; DataMem_Read = 0; DataMem_Write = 0; Mem_Ack = 0; reset = 0;
    #1 checkZeroOutputs("rst2");
    @(negedge clock) reset = 1;
    // Instruction fetch against a zero-wait memory.
    @(negedge clock) begin InstMem_Read = 1; InstMem_Address = 30'h10; end
    @(negedge clock);
    checkEq("fetchReq", Mem_Req, 1);
    checkEq("fetchAddr", Mem_Address, 30'h10);
    checkEq("fetchWe", Mem_We, 0);
    Mem_Ack = 1; Mem_RData = 32'h2402000A;
    @(negedge clock);
    Mem_Ack = 0;
    checkEq("fetchRdy", InstMem_Ready, 1);
    checkEq("fetchIn", InstMem_In, 32'h2402000A);
    @(negedge clock);
    checkEq("fetchRdyOnce", InstMem_Ready, 0);
    InstMem_Read = 0;
    // Data write with five wait states.
    @(negedge clock) begin DataMem_Write = 4'b0011; DataMem_Address = 30'h40; DataMem_Out = 32'hCAFEF00D; end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checkEq("wrReq", Mem_Req, 1);
      checkEq("wrAddr", Mem_Address, 30'h40);
      checkEq("wrWe", Mem_We, 4'b0011);
      checkEq("wrWData", Mem_WData, 32'hCAFEF00D);
      checkEq("wrEarlyRdy", DataMem_Ready, 0);
      Mem_Ack = i == 5;
      Mem_RData = i == 5 ? 32'h13572468 : $urandom;
    end
    @(negedge clock);
    Mem_Ack = 0;
    checkEq("wrReqDrop", Mem_Req, 0);
    checkEq("wrWeDrop", Mem_We, 0);
    checkEq("wrRdy", DataMem_Ready, 1);
    checkEq("wrIn", DataMem_In, 32'h13572468);
    @(negedge clock);
    checkEq("noRegrant", Mem_Req, 0);
    checkEq("wrRdyOnce", DataMem_Ready, 0);
    DataMem_Write = 0;
    // Reset while BUSY, then a stray Ack from the abandoned transaction.
    @(negedge clock) begin DataMem_Read = 1; DataMem_Address = 30'h5; end
    @(negedge clock) checkEq("busyReq", Mem_Req, 1);
    @(negedge clock);
    reset = 0;
    DataMem_Read = 0;
    #1 checkZeroOutputs("midRst");
    @(negedge clock) reset = 1;
    @(negedge clock) begin Mem_Ack = 1; Mem_RData = 32'h0BADF00D; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      Mem_Ack = 0;
      checkEq("strayReq", Mem_Req, 0);
      checkEq("strayDRdy", DataMem_Ready, 0);
      checkEq("strayDIn", DataMem_In, 0);
    end
`ifdef MIPS_MEM_ARB_TIMEOUT_EN
    @(negedge clock) begin DataMem_Read = 1; DataMem_Address = 30'h7; end
    n = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (DataMem_Ready) seen = 1;
      else if (Mem_Req) n++;
    end
    checkEq("toSeen", seen, 1);
    checkEq("toBusyCycles", n, TO);
    checkEq("toData", DataMem_In, ERR);
    checkEq("toFlag", Arb_Timeout, 1);
    @(negedge clock) DataMem_Read = 0;
    @(negedge clock) begin InstMem_Read = 1; InstMem_Address = 30'h3; end
    @(negedge clock) begin Mem_Ack = 1; Mem_RData = 32'h00000001; end
    @(negedge clock);
    Mem_Ack = 0;
    checkEq("toNextRdy", InstMem_Ready, 1);
    checkEq("toSticky", Arb_Timeout, 1);
    InstMem_Read = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Sits between the Processor's split instruction/data memory ports and a single-ported word memory (BFM or on-chip RAM). Serialises InstMem and DataMem requests onto one request/acknowledge bus and returns one-cycle Ready pulses with registered read data. Uses alternating priority on contention so neither port starves.

Parameters:
TIMEOUT_CYCLES, 255, cycles a granted transaction waits for Mem_Ack before forced completion (used only with the optional feature)
ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out transaction

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
DataMem_Read  input  1  data read request, held until DataMem_Ready
DataMem_Write  input  4  byte write enables, held until DataMem_Ready
DataMem_Address  input  30  data word address
DataMem_Out  input  32  data write data from Processor
DataMem_In  output  32  data read data to Processor
DataMem_Ready  output  1  one-cycle completion pulse, data port
InstMem_Read  input  1  fetch request, held until InstMem_Ready
InstMem_Address  input  30  fetch word address
InstMem_In  output  32  fetched instruction
InstMem_Ready  output  1  one-cycle completion pulse, instruction port
Mem_Req  output  1  backing-memory request, held until Mem_Ack
Mem_We  output  4  byte write enables; 0 = read
Mem_Address  output  30  word address
Mem_WData  output  32  write data
Mem_RData  input  32  read data, valid in Mem_Ack cycle
Mem_Ack  input  1  one-cycle completion from memory
Arb_Timeout  output  1  sticky timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset (reset low, async): state IDLE; Mem_Req, Mem_We, Mem_Address, Mem_WData, DataMem_In, InstMem_In = 0; both Ready = 0; last-grant = INST; Arb_Timeout = 0.
- Data pending = DataMem_Read | (|DataMem_Write). Inst pending = InstMem_Read.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE: if exactly one port pending, grant it. If both pending, grant the port opposite last-grant. On grant, register Mem_Address, Mem_We (DataMem_Write for data, 0 for inst), Mem_WData; Mem_Req = 1 next cycle; update last-grant; go BUSY. No pending: stay IDLE.
- Data read and write asserted together: treat as write; DataMem_In still loads Mem_RData.
- BUSY: Mem_Req and all Mem_* outputs held stable. On Mem_Ack: Mem_Req = 0 and Mem_We = 0 next cycle. Load Mem_RData into the granted port's In register. Go RESP.
- RESP: granted port's Ready = 1 for exactly this cycle. Requests are not sampled in RESP, because the Processor still shows the just-served request. Next state IDLE.
- Latency: a request visible at edge k drives Mem_Req from k+1. An Ack in cycle a gives Ready in cycle a+1. Minimum for zero-wait memory: Ready 2 cycles after the request; 3-cycle issue interval.
- DataMem_In and InstMem_In hold their value until the next completion on the same port.
- Request withdrawn during BUSY: the memory transaction still completes, and Ready still pulses once.
- Mem_Ack outside BUSY is ignored.
- Reset mid-transaction: immediate return to reset values. An in-flight memory Ack after reset is ignored.

Optional Feature:
MIPS_MEM_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT_CYCLES without Mem_Ack:
  - drop Mem_Req;
  - load ERR_DATA into the granted port's In register;
  - go RESP (Ready pulses normally);
  - set Arb_Timeout (sticky until reset).
- An Ack arriving in the same cycle as the timeout wins, and the timeout does not fire.
- Not defined: no counter, BUSY waits indefinitely, Arb_Timeout tied 0.

Decomposition:
- Package mips_mem_arb_pkg:
  - state enum {IDLE, BUSY, RESP};
  - grant enum {GNT_INST, GNT_DATA};
  - ERR_DATA default constant;
  - address/data width localparams (30/32).
- Sub-module mips_mem_timeout: the watchdog counter with clear/enable/expired ports. Instantiated only under the macro.

Test Plan:
- Inst-only, InstMem_Address=30'h10, memory Acks on its first Req cycle with 32'h2402000A -> Mem_Req 1 cycle after request; InstMem_Ready one pulse 2 cycles after request; InstMem_In=32'h2402000A.
- Data write: DataMem_Write=4'b0011, address 30'h40, DataMem_Out=32'hCAFEF00D -> Mem_We=4'b0011, Mem_WData=32'hCAFEF00D held until Ack; single DataMem_Ready pulse.
- Both pending from reset -> first grant DATA (last-grant=INST at reset), then INST; requests held continuously alternate D,I,D,I over 4 transactions.
- Memory with 5-cycle wait -> Mem_Req high exactly 6 cycles, address stable throughout, Ready exactly 1 cycle after Ack; no re-grant in RESP cycle.
- reset asserted in BUSY, Ack arriving 2 cycles later -> all outputs 0 immediately; stray Ack produces no Ready.
- With MIPS_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never Acks -> DataMem_Ready after 8 BUSY cycles; DataMem_In=32'hDEADBEEF; Arb_Timeout=1 and sticky.
